// File: rtl/sort_job_arbiter.sv
// Round-robin front end that shares one 4-element sort engine between N_REQ requesters.
// Each job is accepted, issued with a start pulse, and its result (or a timeout error) is returned to the winning requester.
module sort_job_arbiter #(
  parameter int N_REQ   = 2,
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*4*W-1:0]   req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [4*W-1:0]         rsp_data,
  output logic                   rsp_err,
  output logic                   eng_start,
  output logic [4*W-1:0]         eng_x,
  input  logic                   eng_done,
  input  logic [4*W-1:0]         eng_s,
  output logic                   busy,
  output logic [1:0]             grant_id
);

  localparam int IW = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [4*W-1:0]  eng_x_q, eng_x_d;
  logic [4*W-1:0]  rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  int              scan;

  // Rotating priority search starting at rr_ptr
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= N_REQ) scan = scan - N_REQ;
      if (!win_found && req_valid[IW'(scan)]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      eng_x_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      eng_x_q    <= eng_x_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    eng_x_d    = eng_x_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wait_cnt_d = wait_cnt_q;
    req_ready  = '0;
    rsp_valid  = '0;
    eng_start  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          eng_x_d            = req_data[int'(win_idx)*4*W +: 4*W];
          grant_d            = win_idx;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        eng_start  = 1'b1;
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      // A completion on the last allowed cycle still counts as success
      WAIT: begin
        if (eng_done) begin
          rsp_data_d = eng_s;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          if (grant_q == IW'(N_REQ - 1)) rr_ptr_d = '0;
          else                            rr_ptr_d = grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign eng_x    = eng_x_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = 2'(grant_q);

endmodule

// File: tb/tb_sort_job_arbiter.sv
// Directed bench for sort_job_arbiter: the engine is driven by hand from the stimulus,
// and every expected value below is written out explicitly.
module tb_sort_job_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_data;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        eng_start;
  logic [15:0] eng_x;
  logic        eng_done;
  logic [15:0] eng_s;
  logic        busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int viol   = 0;

  sort_job_arbiter #(.N_REQ(2), .W(4), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .eng_start (eng_start),
    .eng_x     (eng_x),
    .eng_done  (eng_done),
    .eng_s     (eng_s),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (eng_start) starts <= starts + 1;
    if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1 || (req_ready != 2'b00 && busy))
      viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // dly < 0 means the engine never answers
  task automatic do_job(input logic [1:0] vmask, input logic [15:0] d0, input logic [15:0] d1,
                        input int g, input int dly, input logic [15:0] res, input logic exp_err,
                        input int hold, input bit keep_valid, input bit done_in_issue);
    int n;
    int s0;
    int bad;
    logic [15:0] exp_d;
    logic [1:0]  gmask;
    gmask = (g == 0) ? 2'b01 : 2'b10;
    exp_d = exp_err ? 16'h0000 : res;
    s0 = starts;
    req_data  = {d1, d0};
    req_valid = vmask;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_ready == 2'b00) begin
      chk("accept_timeout", 32'(n), 32'd0);
      return;
    end
    chk("req_ready", 32'(req_ready), 32'(gmask));
    @(posedge clk); #1;
    if (!keep_valid) req_valid = 2'b00;
    chk("eng_start", 32'(eng_start), 32'd1);
    chk("grant_id", 32'(grant_id), 32'(g));
    chk("eng_x", 32'(eng_x), 32'((g == 0) ? d0 : d1));
    chk("ready_in_issue", 32'(req_ready), 32'd0);
    if (done_in_issue) begin
      eng_done = 1'b1;
      eng_s    = 16'hFFFF;
    end
    @(posedge clk); #1;
    eng_done = 1'b0;
    if (dly >= 0) begin
      repeat (dly) begin @(posedge clk); #1; end
      eng_done = 1'b1;
      eng_s    = res;
    end
    n = 0;
    while (rsp_valid == 2'b00 && n < 40) begin
      @(posedge clk); #1;
      eng_done = 1'b0;
      n++;
    end
    if (dly < 0) chk("timeout_latency", 32'(n), 32'd15);
    else         chk("done_latency", 32'(n), 32'd1);
    if (rsp_valid == 2'b00) return;
    chk("rsp_valid", 32'(rsp_valid), 32'(gmask));
    chk("rsp_data", 32'(rsp_data), 32'(exp_d));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("busy_resp", 32'(busy), 32'd1);
    rsp_ready = ~gmask;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rsp_valid != gmask || rsp_data != exp_d || rsp_err != exp_err || req_ready != 2'b00 || !busy)
        bad++;
    end
    if (hold > 0) chk("hold_stable", 32'(bad), 32'd0);
    rsp_ready = gmask;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    chk("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("start_pulses", 32'(starts - s0), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 2'b00; req_data = 32'h0; rsp_ready = 2'b00;
    eng_done = 1'b0; eng_s = 16'h0;
    do_reset();

    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_eng_x", 32'(eng_x), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);

    // single job, engine answers on its 4th WAIT cycle
    do_job(2'b01, 16'h3918, 16'h0000, 0, 3, 16'h1389, 1'b0, 0, 1'b0, 1'b0);

    // both requesters held valid: grants alternate 0,1,0
    do_reset();
    do_job(2'b11, 16'h1111, 16'h2222, 0, 1, 16'h4321, 1'b0, 0, 1'b1, 1'b0);
    do_job(2'b11, 16'h1111, 16'h2222, 1, 0, 16'h8765, 1'b0, 0, 1'b1, 1'b0);
    do_job(2'b11, 16'h1111, 16'h2222, 0, 2, 16'hC0DE, 1'b0, 0, 1'b0, 1'b0);

    // engine never answers
    do_job(2'b01, 16'h0F0F, 16'h0000, 0, -1, 16'h0000, 1'b1, 0, 1'b0, 1'b0);

    // done coincides with the final WAIT cycle
    do_job(2'b10, 16'h0000, 16'h5A5A, 1, 14, 16'hABCD, 1'b0, 0, 1'b0, 1'b0);

    // response stalled 10 cycles, done during ISSUE must be ignored
    do_job(2'b11, 16'h7777, 16'h8888, 0, 2, 16'h9876, 1'b0, 10, 1'b1, 1'b1);
    req_valid = 2'b00;

    // reset in the middle of WAIT
    req_data  = {16'h6543, 16'h0000};
    req_valid = 2'b10;
    #1;
    chk("t6_req_ready", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_grant_id", 32'(grant_id), 32'd0);
    chk("t6_eng_x", 32'(eng_x), 32'd0);
    chk("t6_eng_start", 32'(eng_start), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    eng_done = 1'b1;
    eng_s = 16'h1234;
    n = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid != 2'b00 || busy) n++;
    end
    eng_done = 1'b0;
    chk("t6_no_rsp", 32'(n), 32'd0);
    do_job(2'b11, 16'h2468, 16'h1357, 0, 1, 16'h8642, 1'b0, 0, 1'b0, 1'b0);

    chk("onehot_viol", 32'(viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d want %0d", 1, 0);
    $fatal(1);
  end

endmodule
